// File: rtl/conv3x3_pkg.sv
// Shared widths, array types and helpers for the 3x3 convolution MAC.
package conv3x3_pkg;

  localparam int unsigned WORD_WIDTH   = 8;
  localparam int unsigned WEIGHT_WIDTH = 8;
  localparam int unsigned NUM_TAPS     = 9;
  localparam int unsigned PROD_WIDTH   = WORD_WIDTH + WEIGHT_WIDTH;
  localparam int unsigned ROW_WIDTH    = PROD_WIDTH + 2;
  localparam int unsigned SUM_WIDTH    = PROD_WIDTH + 4;
  localparam int unsigned WT_BUS_WIDTH = NUM_TAPS * WEIGHT_WIDTH;

  typedef logic signed [WORD_WIDTH-1:0]   window_t  [NUM_TAPS];
  typedef logic signed [WEIGHT_WIDTH-1:0] weights_t [NUM_TAPS];

  // Control bits that travel alongside each pipeline stage.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    logic img_last;
  } stage_ctl_t;

  // Split the packed weight word into taps w00..w22 (w00 in the LSBs).
  function automatic weights_t unpack_weights(input logic [WT_BUS_WIDTH-1:0] raw);
    weights_t w;
    for (int i = 0; i < int'(NUM_TAPS); i++) begin
      w[i] = raw[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
    return w;
  endfunction

endpackage

// File: rtl/conv3x3_mac_accum_if.sv
// Parameter, weight, window and result signals of the convolution MAC.
interface conv3x3_mac_accum_if #(
  parameter int unsigned MAX_TRANSFERS = 512,
  parameter int unsigned ACC_WIDTH     = 32
);
  localparam int unsigned CNT_WIDTH = $clog2(MAX_TRANSFERS) + 1;

  logic                                   i_load_param;
  logic [CNT_WIDTH-1:0]                   i_transfers;
  logic [ACC_WIDTH-1:0]                   i_bias;
  logic                                   i_wt_valid;
  logic [conv3x3_pkg::WT_BUS_WIDTH-1:0]   i_wt_data;
  logic                                   i_win_valid;
  logic                                   i_win_last;
  logic [conv3x3_pkg::WORD_WIDTH-1:0]     i_win_00, i_win_01, i_win_02;
  logic [conv3x3_pkg::WORD_WIDTH-1:0]     i_win_10, i_win_11, i_win_12;
  logic [conv3x3_pkg::WORD_WIDTH-1:0]     i_win_20, i_win_21, i_win_22;
  logic                                   o_valid;
  logic                                   o_last;
  logic [ACC_WIDTH-1:0]                   o_data;

  modport master (
    output i_load_param, i_transfers, i_bias, i_wt_valid, i_wt_data,
           i_win_valid, i_win_last,
           i_win_00, i_win_01, i_win_02, i_win_10, i_win_11, i_win_12,
           i_win_20, i_win_21, i_win_22,
    input  o_valid, o_last, o_data
  );

  modport slave (
    input  i_load_param, i_transfers, i_bias, i_wt_valid, i_wt_data,
           i_win_valid, i_win_last,
           i_win_00, i_win_01, i_win_02, i_win_10, i_win_11, i_win_12,
           i_win_20, i_win_21, i_win_22,
    output o_valid, o_last, o_data
  );

endinterface

// File: rtl/conv3x3_weight_ram.sv
// Simple dual-port weight store: one write port, synchronous read-first read port.
module conv3x3_weight_ram #(
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned WIDTH      = 72,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Read samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv3x3_mac_accum.sv
// 3x3 window MAC: per-transfer dot product against stored weights,
// accumulated over all transfers of a pixel plus bias, one result per pixel.
module conv3x3_mac_accum
  import conv3x3_pkg::*;
#(
  parameter int unsigned MAX_TRANSFERS = 512,
  parameter int unsigned ACC_WIDTH     = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  conv3x3_mac_accum_if.slave bus
);

  localparam int unsigned CNT_WIDTH  = $clog2(MAX_TRANSFERS) + 1;
  localparam int unsigned ADDR_WIDTH = $clog2(MAX_TRANSFERS);

  logic [CNT_WIDTH-1:0] transfers_q, transfers_d;
  logic [ACC_WIDTH-1:0] bias_q, bias_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d;
  logic [CNT_WIDTH-1:0] wt_addr_q, wt_addr_d;
  logic [CNT_WIDTH-1:0] final_idx_c;
  logic                 win_accept_c, wt_write_c, first_c, last_c;

  window_t                   taps_c, taps0_q;
  weights_t                  wts_c;
  logic [WT_BUS_WIDTH-1:0]   ram_rdata;
  logic signed [PROD_WIDTH-1:0] prod1_q [NUM_TAPS];
  logic signed [ROW_WIDTH-1:0]  row2_q  [3];
  logic signed [SUM_WIDTH-1:0]  sum3_q;

  stage_ctl_t ctl0_q, ctl1_q, ctl2_q, ctl3_q;

  logic [ACC_WIDTH-1:0] sum_ext_c, acc_d, acc_q;
  logic                 o_valid_q, o_last_q;
  logic [ACC_WIDTH-1:0] o_data_q;

  // Parameter capture, transfer index and weight write address.
  always_comb begin
    transfers_d  = transfers_q;
    bias_d       = bias_q;
    idx_d        = idx_q;
    wt_addr_d    = wt_addr_q;
    final_idx_c  = transfers_q - CNT_WIDTH'(1);
    first_c      = (idx_q == '0);
    last_c       = (idx_q == final_idx_c);
    win_accept_c = bus.i_win_valid && !bus.i_load_param;
    wt_write_c   = bus.i_wt_valid && !bus.i_load_param;
    if (bus.i_load_param) begin
      transfers_d = (bus.i_transfers == '0) ? CNT_WIDTH'(1) : bus.i_transfers;
      bias_d      = bus.i_bias;
      idx_d       = '0;
      wt_addr_d   = '0;
    end else begin
      if (win_accept_c) begin
        idx_d = last_c ? '0 : idx_q + CNT_WIDTH'(1);
      end
      if (wt_write_c) begin
        wt_addr_d = (wt_addr_q == final_idx_c) ? '0 : wt_addr_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      transfers_q <= CNT_WIDTH'(1);
      bias_q      <= '0;
      idx_q       <= '0;
      wt_addr_q   <= '0;
    end else begin
      transfers_q <= transfers_d;
      bias_q      <= bias_d;
      idx_q       <= idx_d;
      wt_addr_q   <= wt_addr_d;
    end
  end

  conv3x3_weight_ram #(
    .DEPTH      (MAX_TRANSFERS),
    .WIDTH      (WT_BUS_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_weight_ram (
    .clk     (i_clk),
    .we_i    (wt_write_c),
    .waddr_i (wt_addr_q[ADDR_WIDTH-1:0]),
    .wdata_i (bus.i_wt_data),
    .raddr_i (idx_q[ADDR_WIDTH-1:0]),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    taps_c[0] = bus.i_win_00;
    taps_c[1] = bus.i_win_01;
    taps_c[2] = bus.i_win_02;
    taps_c[3] = bus.i_win_10;
    taps_c[4] = bus.i_win_11;
    taps_c[5] = bus.i_win_12;
    taps_c[6] = bus.i_win_20;
    taps_c[7] = bus.i_win_21;
    taps_c[8] = bus.i_win_22;
    wts_c     = unpack_weights(ram_rdata);
  end

  // Datapath: products, row sums, window sum. Bubbles are tracked by ctl*_q.
  always_ff @(posedge i_clk) begin
    if (win_accept_c) begin
      taps0_q <= taps_c;
    end
    if (ctl0_q.valid) begin
      for (int i = 0; i < int'(NUM_TAPS); i++) begin
        prod1_q[i] <= PROD_WIDTH'(taps0_q[i]) * PROD_WIDTH'(wts_c[i]);
      end
    end
    if (ctl1_q.valid) begin
      for (int r = 0; r < 3; r++) begin
        row2_q[r] <= ROW_WIDTH'(prod1_q[3*r]) + ROW_WIDTH'(prod1_q[3*r+1])
                   + ROW_WIDTH'(prod1_q[3*r+2]);
      end
    end
    if (ctl2_q.valid) begin
      sum3_q <= SUM_WIDTH'(row2_q[0]) + SUM_WIDTH'(row2_q[1]) + SUM_WIDTH'(row2_q[2]);
    end
  end

  always_comb begin
    sum_ext_c = ACC_WIDTH'(sum3_q);
    acc_d     = ctl3_q.first ? (bias_q + sum_ext_c) : (acc_q + sum_ext_c);
  end

  // Stage control, accumulator and registered outputs; reload flushes in-flight work.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ctl0_q    <= '0;
      ctl1_q    <= '0;
      ctl2_q    <= '0;
      ctl3_q    <= '0;
      acc_q     <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_data_q  <= '0;
    end else if (bus.i_load_param) begin
      ctl0_q    <= '0;
      ctl1_q    <= '0;
      ctl2_q    <= '0;
      ctl3_q    <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end else begin
      ctl0_q    <= '{valid: win_accept_c, first: first_c, last: last_c,
                     img_last: bus.i_win_last};
      ctl1_q    <= ctl0_q;
      ctl2_q    <= ctl1_q;
      ctl3_q    <= ctl2_q;
      o_valid_q <= ctl3_q.valid && ctl3_q.last;
      o_last_q  <= ctl3_q.valid && ctl3_q.last && ctl3_q.img_last;
      if (ctl3_q.valid) begin
        acc_q <= acc_d;
      end
      if (ctl3_q.valid && ctl3_q.last) begin
        o_data_q <= acc_d;
      end
    end
  end

  assign bus.o_valid = o_valid_q;
  assign bus.o_last  = o_last_q;
  assign bus.o_data  = o_data_q;

endmodule

// File: tb/tb_conv3x3_mac_accum.sv
// Self-checking bench: directed table, multi-cycle corner sequences and
// randomized pixels scored against an arithmetic reference.
`timescale 1ns/1ps
module tb_conv3x3_mac_accum;

  localparam int unsigned MAXT = 512;
  localparam int unsigned ACCW = 32;
  localparam int unsigned CW   = $clog2(MAXT) + 1;

  typedef int arr9_t [9];
  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;
  typedef struct {
    int n;
    int bias;
    int wconst;   // 0 selects weights 1..9
    int tap0;
    int tstep;
    bit last;
    int exp_data;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];
  vec_t vt[6];

  always #5 clk = ~clk;

  conv3x3_mac_accum_if #(.MAX_TRANSFERS(MAXT), .ACC_WIDTH(ACCW)) bus ();

  conv3x3_mac_accum #(.MAX_TRANSFERS(MAXT), .ACC_WIDTH(ACCW)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)",
               name, got, $signed(got), exp, $signed(exp));
    end
  endtask

  // Scoreboard: every result strobe must match the oldest expected pixel.
  always @(negedge clk) begin
    if (rst_n && bus.o_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_o_valid", 32'(bus.o_data), 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("o_data", bus.o_data, e.data);
        chk("o_last", 32'(bus.o_last), 32'(e.last));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_load_param = 1'b0;
    bus.i_transfers  = '0;
    bus.i_bias       = '0;
    bus.i_wt_valid   = 1'b0;
    bus.i_wt_data    = '0;
    bus.i_win_valid  = 1'b0;
    bus.i_win_last   = 1'b0;
  endtask

  task automatic load_params(input int n, input int bias);
    bus.i_win_valid  = 1'b0;
    bus.i_load_param = 1'b1;
    bus.i_transfers  = CW'(n);
    bus.i_bias       = 32'(bias);
    tick();
    bus.i_load_param = 1'b0;
  endtask

  task automatic write_wt(input arr9_t w);
    for (int i = 0; i < 9; i++) bus.i_wt_data[i*8 +: 8] = 8'(w[i]);
    bus.i_wt_valid = 1'b1;
    tick();
    bus.i_wt_valid = 1'b0;
  endtask

  task automatic drive_win(input arr9_t t, input bit last);
    bus.i_win_00 = 8'(t[0]); bus.i_win_01 = 8'(t[1]); bus.i_win_02 = 8'(t[2]);
    bus.i_win_10 = 8'(t[3]); bus.i_win_11 = 8'(t[4]); bus.i_win_12 = 8'(t[5]);
    bus.i_win_20 = 8'(t[6]); bus.i_win_21 = 8'(t[7]); bus.i_win_22 = 8'(t[8]);
    bus.i_win_valid = 1'b1;
    bus.i_win_last  = last;
  endtask

  task automatic send_win(input arr9_t t, input bit last);
    drive_win(t, last);
    tick();
    bus.i_win_valid = 1'b0;
    bus.i_win_last  = 1'b0;
  endtask

  function automatic longint dot(input arr9_t t, input arr9_t w);
    longint s = 0;
    for (int i = 0; i < 9; i++) s += longint'(t[i]) * longint'(w[i]);
    return s;
  endfunction

  function automatic arr9_t rand9();
    arr9_t a;
    for (int i = 0; i < 9; i++) a[i] = int'($urandom_range(0, 255)) - 128;
    return a;
  endfunction

  function automatic arr9_t fill9(input int v);
    arr9_t a;
    for (int i = 0; i < 9; i++) a[i] = v;
    return a;
  endfunction

  task automatic push(input longint acc, input bit last);
    exp_t e;
    e.data = 32'(acc);
    e.last = last;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() != 0; k++) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
    tick();
  endtask

  initial begin
    arr9_t w, w0, w1, t;
    arr9_t tt[8];
    int    n, nn, vcnt, lcnt, adj, pv;
    longint acc;

    vt[0] = '{n: 1, bias: 0,          wconst: 0,    tap0: 1,    tstep: 0, last: 1'b1, exp_data: 45};
    vt[1] = '{n: 3, bias: 10,         wconst: 1,    tap0: 1,    tstep: 1, last: 1'b0, exp_data: 64};
    vt[2] = '{n: 4, bias: 0,          wconst: -128, tap0: -128, tstep: 0, last: 1'b0, exp_data: 589824};
    vt[3] = '{n: 4, bias: 0,          wconst: 127,  tap0: -128, tstep: 0, last: 1'b1, exp_data: -585216};
    vt[4] = '{n: 0, bias: 5,          wconst: 0,    tap0: 2,    tstep: 0, last: 1'b0, exp_data: 95};
    vt[5] = '{n: 1, bias: 2147483647, wconst: 1,    tap0: 1,    tstep: 0, last: 1'b1, exp_data: -2147483640};

    idle_inputs();
    t = fill9(0);
    drive_win(t, 1'b0);
    bus.i_win_valid = 1'b0;
    repeat (3) tick();
    chk("reset_o_valid", 32'(bus.o_valid), 32'd0);
    chk("reset_o_last",  32'(bus.o_last),  32'd0);
    chk("reset_o_data",  bus.o_data,       32'd0);
    rst_n = 1'b1;
    tick();

    // Directed table.
    for (int v = 0; v < 6; v++) begin
      n  = vt[v].n;
      nn = (n == 0) ? 1 : n;
      load_params(n, vt[v].bias);
      for (int k = 0; k < nn; k++) begin
        for (int i = 0; i < 9; i++) w[i] = (vt[v].wconst == 0) ? i + 1 : vt[v].wconst;
        write_wt(w);
      end
      for (int k = 0; k < nn; k++) begin
        send_win(fill9(vt[v].tap0 + k * vt[v].tstep), vt[v].last && (k == nn - 1));
      end
      push(longint'(vt[v].exp_data), vt[v].last);
      drain();
    end

    // Single-transfer latency: strobe exactly on the fourth edge.
    load_params(1, 0);
    for (int i = 0; i < 9; i++) w[i] = i + 1;
    write_wt(w);
    push(45, 1'b0);
    send_win(fill9(1), 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("latency_edge%0d", k), 32'(bus.o_valid), 32'(k == 4));
    end
    drain();

    // Back-to-back stream, two transfers per pixel.
    load_params(2, 0);
    w0 = rand9(); w1 = rand9();
    write_wt(w0);
    write_wt(w1);
    for (int c = 0; c < 8; c++) tt[c] = rand9();
    for (int p = 0; p < 4; p++) push(dot(tt[2*p], w0) + dot(tt[2*p+1], w1), p == 3);
    vcnt = 0; lcnt = 0; adj = 0; pv = 0;
    for (int c = 0; c < 16; c++) begin
      if (c < 8) drive_win(tt[c], c >= 6);
      else begin bus.i_win_valid = 1'b0; bus.i_win_last = 1'b0; end
      tick();
      if (bus.o_valid && pv != 0) adj++;
      pv = int'(bus.o_valid);
      vcnt += int'(bus.o_valid);
      lcnt += int'(bus.o_last);
    end
    bus.i_win_valid = 1'b0; bus.i_win_last = 1'b0;
    chk("b2b_valid_count", 32'(vcnt), 32'd4);
    chk("b2b_last_count",  32'(lcnt), 32'd1);
    chk("b2b_adjacent",    32'(adj),  32'd0);
    drain();

    // Flush: reload with three windows in flight.
    load_params(1, 7);
    w = rand9();
    write_wt(w);
    for (int c = 0; c < 3; c++) begin
      drive_win(rand9(), 1'b0);
      tick();
    end
    load_params(1, 7);
    vcnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      vcnt += int'(bus.o_valid);
    end
    chk("flush_no_valid", 32'(vcnt), 32'd0);
    t = rand9();
    push(dot(t, w) + 7, 1'b1);
    send_win(t, 1'b1);
    drain();

    // Async reset while a result strobe is high.
    load_params(1, 0);
    for (int i = 0; i < 9; i++) w[i] = i + 1;
    write_wt(w);
    for (int c = 0; c < 6; c++) begin
      push(45, 1'b1);
      drive_win(fill9(1), 1'b1);
      tick();
    end
    #1;
    rst_n = 1'b0;
    bus.i_win_valid = 1'b0;
    #1;
    chk("async_rst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("async_rst_o_last",  32'(bus.o_last),  32'd0);
    chk("async_rst_o_data",  bus.o_data,       32'd0);
    q.delete();
    repeat (2) tick();
    #2;
    rst_n = 1'b1;
    tick();
    w = rand9();
    write_wt(w);
    t = rand9();
    push(dot(t, w), 1'b0);
    send_win(t, 1'b0);
    drain();

    // Randomized pixels with gaps.
    for (int r = 0; r < 6; r++) begin
      arr9_t wr[8];
      int    bias, npix;
      n    = int'($urandom_range(1, 6));
      bias = int'($urandom);
      npix = int'($urandom_range(2, 5));
      load_params(n, bias);
      for (int k = 0; k < n; k++) begin
        wr[k] = rand9();
        write_wt(wr[k]);
      end
      for (int p = 0; p < npix; p++) begin
        acc = longint'(bias);
        for (int k = 0; k < n; k++) begin
          repeat ($urandom_range(0, 2)) tick();
          t = rand9();
          acc += dot(t, wr[k]);
          if (k == n - 1) push(acc, p == npix - 1);
          send_win(t, (p == npix - 1) && (k == n - 1));
        end
      end
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
